// File: rtl/sine_period_meter.sv
// Measures the period and peak-to-peak amplitude of a sampled sine wave using hysteresis crossings.
// Latency: meas_valid and timeout are registered and rise one clk after the accepted sample that triggers them.
// Backpressure: none; every accepted sample is consumed on its edge, and sample is ignored while sample_valid=0.
module sine_period_meter #(
  parameter int WIDTH     = 14,
  parameter int HYST      = 64,
  parameter int TIMEOUT   = 100000,
  parameter int CNT_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [WIDTH-1:0]     sample,
  input  logic                        sample_valid,
  output logic        [CNT_WIDTH-1:0] period,
  output logic        [WIDTH:0]       peak_to_peak,
  output logic                        meas_valid,
  output logic                        timeout
);

  // Hysteresis thresholds as signed sample-width constants.
  localparam logic signed [WIDTH-1:0] HI_TH = WIDTH'(HYST);
  localparam logic signed [WIDTH-1:0] LO_TH = WIDTH'(-HYST);
  localparam logic [CNT_WIDTH-1:0]    TO_CNT = CNT_WIDTH'(TIMEOUT);

  // INIT_* wait for the first rising crossing; MEAS_LOW is armed for a low
  // sample, MEAS_HIGH is armed for the rising crossing that closes a period.
  typedef enum logic [1:0] {
    INIT_LOW,
    INIT_HIGH,
    MEAS_LOW,
    MEAS_HIGH
  } state_t;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic signed [WIDTH-1:0] trk_max;
  logic signed [WIDTH-1:0] trk_min;

  logic                   is_low;
  logic                   is_high;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic signed [WIDTH-1:0] run_max;
  logic signed [WIDTH-1:0] run_min;
  logic [WIDTH:0]         p2p;

  // Threshold compares, running extremes including the current sample, and the
  // sign-extended difference, which cannot overflow in WIDTH+1 bits.
  always_comb begin
    is_low  = (sample <= LO_TH);
    is_high = (sample >= HI_TH);
    cnt_inc = cnt + 1'b1;
    run_max = (sample > trk_max) ? sample : trk_max;
    run_min = (sample < trk_min) ? sample : trk_min;
    p2p     = {run_max[WIDTH-1], run_max} - {run_min[WIDTH-1], run_min};
  end

  // Crossing FSM with the period counter, extreme trackers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= INIT_LOW;
      cnt          <= '0;
      trk_max      <= '0;
      trk_min      <= '0;
      period       <= '0;
      peak_to_peak <= '0;
      meas_valid   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      if (sample_valid) begin
        case (state)
          INIT_LOW: begin
            if (is_low) state <= INIT_HIGH;
          end
          INIT_HIGH: begin
            // First rising crossing opens a period but reports nothing.
            if (is_high) begin
              state   <= MEAS_LOW;
              cnt     <= '0;
              trk_max <= sample;
              trk_min <= sample;
            end
          end
          MEAS_LOW, MEAS_HIGH: begin
            if (state == MEAS_HIGH && is_high) begin
              // Rising crossing closes the period; it wins over a coincident timeout.
              state        <= MEAS_LOW;
              period       <= cnt_inc;
              peak_to_peak <= p2p;
              meas_valid   <= 1'b1;
              cnt          <= '0;
              trk_max      <= sample;
              trk_min      <= sample;
            end else if (cnt_inc == TO_CNT) begin
              // No crossing in time: drop the partial period, keep the last result.
              state   <= INIT_LOW;
              timeout <= 1'b1;
              cnt     <= '0;
              trk_max <= '0;
              trk_min <= '0;
            end else begin
              cnt     <= cnt_inc;
              trk_max <= run_max;
              trk_min <= run_min;
              if (state == MEAS_LOW && is_low) state <= MEAS_HIGH;
            end
          end
          default: state <= INIT_LOW;
        endcase
      end
    end
  end

endmodule

// File: doc/sine_period_meter.md
SINE_PERIOD_METER -- requirements
Module: sine_period_meter

Interface
REQ-001 Parameter WIDTH, default 14: sample width in bits, signed two's complement.
REQ-002 Parameter HYST, default 64: hysteresis threshold in LSB, positive, less than 2**(WIDTH-1).
REQ-003 Parameter TIMEOUT, default 100000: maximum valid samples between rising crossings.
REQ-004 Parameter CNT_WIDTH, default 20: period counter width; SHALL satisfy 2**CNT_WIDTH > TIMEOUT.
REQ-005 Port clk  in  1  single clock; all logic on rising edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port sample  in  WIDTH signed  input sine sample from the upstream sine source.
REQ-008 Port sample_valid  in  1  qualifies sample; sample is ignored while low.
REQ-009 Port period  out  CNT_WIDTH unsigned  last measured period in valid samples.
REQ-010 Port peak_to_peak  out  WIDTH+1 unsigned  max minus min sample over the last measured period.
REQ-011 Port meas_valid  out  1  one-cycle pulse when period and peak_to_peak update.
REQ-012 Port timeout  out  1  one-cycle pulse when no crossing occurs within TIMEOUT samples.

Function
REQ-013 Accepted sample: a sample on a clk edge with sample_valid=1; no state, counter or tracker changes on other edges.
REQ-014 Low condition: sample <= -HYST. High condition: sample >= +HYST. Equality counts.
REQ-015 FSM states: INIT_LOW, INIT_HIGH, MEAS_LOW, MEAS_HIGH; reset state INIT_LOW.
REQ-016 INIT_LOW -> INIT_HIGH on an accepted low sample.
REQ-017 INIT_HIGH -> MEAS_LOW on an accepted high sample (first rising crossing): cnt<=0, max<=sample, min<=sample, no meas_valid.
REQ-018 MEAS_LOW -> MEAS_HIGH on an accepted low sample.
REQ-019 MEAS_HIGH -> MEAS_LOW on an accepted high sample (rising crossing): period<=cnt+1, peak_to_peak<=max(max,sample)-min(min,sample), meas_valid=1 on the next cycle, then cnt<=0, max<=sample, min<=sample.
REQ-020 In MEAS_LOW/MEAS_HIGH, every non-crossing accepted sample increments cnt by 1 and updates max/min.
REQ-021 Samples between thresholds never change state; chatter inside ±HYST produces no crossing.
REQ-022 Timeout: in MEAS_LOW/MEAS_HIGH, a non-crossing accepted sample with cnt+1 = TIMEOUT pulses timeout on the next cycle and returns the FSM to INIT_LOW.
REQ-023 On timeout, period and peak_to_peak hold their last values; cnt, max and min are cleared.
REQ-024 A crossing and the timeout condition on the same sample: the crossing wins and no timeout pulse is generated.
REQ-025 peak_to_peak difference is computed in WIDTH+1 bits and never overflows; its range is 0..2**WIDTH-1.
REQ-026 meas_valid and timeout are registered; each is high for exactly one cycle per event, one cycle after the triggering sample edge.
REQ-027 period and peak_to_peak change only on the same edge that asserts meas_valid.
REQ-028 cnt never wraps; the timeout mechanism bounds it below TIMEOUT.

Reset
REQ-029 While reset=1: state=INIT_LOW, cnt=0, max=0, min=0, period=0, peak_to_peak=0, meas_valid=0, timeout=0.
REQ-030 reset=1 has priority over every input, including sample_valid and crossings on the same edge.
REQ-031 After reset mid-measurement, no meas_valid occurs until two new rising crossings have been seen.

Verification
REQ-032 Square stimulus, 50 samples at +1000 then 50 at -1000, repeated, valid always 1 -> from the second rising crossing, meas_valid every 100 cycles, period=100, peak_to_peak=2000.
REQ-033 Same stimulus, sample_valid toggling 1/0 -> period=100, peak_to_peak=2000, meas_valid spacing 200 clk cycles.
REQ-034 Samples alternating +30/-30 (HYST=64) for 10000 samples -> no meas_valid, no timeout, period stays 0.
REQ-035 One rising crossing, then constant 0 -> timeout pulses exactly on the TIMEOUT-th accepted sample after the crossing, FSM returns to INIT_LOW, period unchanged.
REQ-036 Boundary: samples exactly -64 then +64, alternating every 10 samples -> crossings detected, period=20, peak_to_peak=128.
REQ-037 reset pulsed mid-period on the REQ-032 stimulus -> all outputs 0 on the following cycle; first new meas_valid only after two further rising crossings, with period=100.
